// File: rtl/crack_pkg.sv
// Shared constants, charset mapping and FSM state type for the password-crack workers.
package crack_pkg;

    localparam int PW_LEN      = 4;
    localparam int NUM_SYMBOLS = 36;
    localparam int IDX_W       = 6;
    localparam int PW_W        = PW_LEN * 8;

    localparam logic [7:0] CHAR_A      = 8'h61;
    localparam logic [7:0] CHAR_0      = 8'h30;
    localparam int         NUM_LETTERS = 26;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_SYMBOLS - 1);

    // Digit PW_LEN-1 is the first (most significant) character.
    typedef logic [PW_LEN-1:0][IDX_W-1:0] digits_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    function automatic logic [7:0] idx_to_ascii(input logic [IDX_W-1:0] idx);
        if (int'(idx) < NUM_LETTERS) return CHAR_A + 8'(idx);
        return CHAR_0 + 8'(idx) - 8'(NUM_LETTERS);
    endfunction

endpackage

// File: rtl/range_search_worker_if.sv
// Job/result bundle between the cracker top (master) and one range_search_worker (slave).
// CRACK_ATTEMPT_COUNT_EN adds the attempts counter output.
interface range_search_worker_if;
    import crack_pkg::*;

    logic               job_valid;
    logic               job_ready;
    logic [PW_W-1:0]    job_target;
    logic [IDX_W-1:0]   job_from;
    logic [IDX_W-1:0]   job_to;
    logic               abort;
    logic               done;
    logic               found;
    logic               bad_job;
    logic               aborted;
    logic [PW_W-1:0]    result_pw;
`ifdef CRACK_ATTEMPT_COUNT_EN
    logic [31:0]        attempts;
`endif

    modport master (
        output job_valid, job_target, job_from, job_to, abort,
        input  job_ready, done, found, bad_job, aborted, result_pw
`ifdef CRACK_ATTEMPT_COUNT_EN
        , input attempts
`endif
    );

    modport slave (
        input  job_valid, job_target, job_from, job_to, abort,
        output job_ready, done, found, bad_job, aborted, result_pw
`ifdef CRACK_ATTEMPT_COUNT_EN
        , output attempts
`endif
    );

endinterface

// File: rtl/crack_mixed_radix_counter.sv
// Radix-NUM_SYMBOLS candidate counter; last char is the fastest digit.
// 'last' flags the final candidate of the range {limit, max, .., max}.
module crack_mixed_radix_counter
    import crack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [IDX_W-1:0] load_first,
    input  logic [IDX_W-1:0] limit,
    output digits_t          digits,
    output logic             last
);

    digits_t digits_next;
    logic    carry;

    always_comb begin
        digits_next = digits;
        carry       = inc;
        for (int k = 0; k < PW_LEN; k++) begin
            if (carry) begin
                if (digits[k] == IDX_MAX && k != PW_LEN - 1) begin
                    digits_next[k] = '0;
                end else begin
                    digits_next[k] = digits[k] + 1'b1;
                    carry          = 1'b0;
                end
            end
        end
        if (load) begin
            digits_next             = '0;
            digits_next[PW_LEN-1]   = load_first;
        end
    end

    always_comb begin
        last = (digits[PW_LEN-1] == limit);
        for (int k = 0; k < PW_LEN - 1; k++) begin
            if (digits[k] != IDX_MAX) last = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) digits <= '0;
        else     digits <= digits_next;
    end

endmodule

// File: rtl/range_search_worker.sv
// Brute-force worker: enumerates all candidates whose first char is in [job_from, job_to].
// CRACK_ATTEMPT_COUNT_EN adds a saturating count of candidates compared in the current job.
module range_search_worker
    import crack_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    range_search_worker_if.slave bus
);

    state_t           state, state_next;
    logic [PW_W-1:0]  target;
    logic [PW_W-1:0]  candidate;
    logic [IDX_W-1:0] limit;
    logic             bad_pending;
    digits_t          digits;
    logic             last;
    logic             accept, bad_in, match;
    logic             load, inc;
    logic             fin_found, fin_miss, fin_abort, fin_bad;
    logic             done_q, found_q, bad_q, aborted_q;
    logic [PW_W-1:0]  result_q;

    assign bus.job_ready = (state != SEARCH);
    assign accept        = bus.job_valid & bus.job_ready;
    assign bad_in        = (bus.job_from > bus.job_to) || (bus.job_to > IDX_MAX);

    always_comb begin
        candidate = '0;
        for (int k = 0; k < PW_LEN; k++) candidate[k*8 +: 8] = idx_to_ascii(digits[k]);
    end

    assign match = (candidate == target) && !bad_pending;

    crack_mixed_radix_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .inc        (inc),
        .load_first (bus.job_from),
        .limit      (limit),
        .digits     (digits),
        .last       (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A bad job still spends one SEARCH cycle so that done rises one edge after accept.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        inc        = 1'b0;
        fin_found  = 1'b0;
        fin_miss   = 1'b0;
        fin_abort  = 1'b0;
        fin_bad    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = SEARCH;
                    load       = 1'b1;
                end
            end
            SEARCH: begin
                if (bad_pending)    fin_bad   = 1'b1;
                else if (match)     fin_found = 1'b1;
                else if (bus.abort) fin_abort = 1'b1;
                else if (last)      fin_miss  = 1'b1;
                else                inc       = 1'b1;
                if (fin_bad || fin_found || fin_abort || fin_miss) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target      <= '0;
            limit       <= '0;
            bad_pending <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            bad_q       <= 1'b0;
            aborted_q   <= 1'b0;
            result_q    <= '0;
        end else if (accept) begin
            target      <= bus.job_target;
            limit       <= bus.job_to;
            bad_pending <= bad_in;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            bad_q       <= 1'b0;
            aborted_q   <= 1'b0;
            result_q    <= '0;
        end else begin
            if (fin_bad || fin_found || fin_abort || fin_miss) done_q <= 1'b1;
            if (fin_bad)   bad_q     <= 1'b1;
            if (fin_abort) aborted_q <= 1'b1;
            if (fin_found) begin
                found_q  <= 1'b1;
                result_q <= candidate;
            end
        end
    end

    assign bus.done      = done_q;
    assign bus.found     = found_q;
    assign bus.bad_job   = bad_q;
    assign bus.aborted   = aborted_q;
    assign bus.result_pw = result_q;

`ifdef CRACK_ATTEMPT_COUNT_EN
    logic [31:0] attempts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                      attempts_q <= '0;
        else if (accept)                                              attempts_q <= '0;
        else if (state == SEARCH && !bad_pending && attempts_q != '1) attempts_q <= attempts_q + 1'b1;
    end

    assign bus.attempts = attempts_q;
`endif

endmodule

// File: tb/tb_range_search_worker.sv
// Scoreboard bench for range_search_worker: stimulus pushes model results, a negedge monitor checks them.
module tb_range_search_worker;
    import crack_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    range_search_worker_if bus();

    range_search_worker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic            found;
        logic            bad;
        logic            aborted;
        logic [PW_W-1:0] result;
        int              cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    localparam int PER_FIRST = 36 * 36 * 36;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic int sym_idx(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7a) return int'(c) - 32'h61;
        if (c >= 8'h30 && c <= 8'h39) return 26 + int'(c) - 32'h30;
        return -1;
    endfunction

    function automatic logic [7:0] sym_char(input int i);
        if (i < 26) return 8'(32'h61 + i);
        return 8'(32'h30 + i - 26);
    endfunction

    function automatic logic [PW_W-1:0] mk_pw(input int c0, input int c1, input int c2, input int c3);
        return {sym_char(c0), sym_char(c1), sym_char(c2), sym_char(c3)};
    endfunction

    // Reference: position of the target in lexicographic order decides latency.
    function automatic exp_t model(input logic [PW_W-1:0] tgt, input int from, input int to);
        exp_t e;
        int   pos = 0;
        bit   ok  = 1'b1;
        int   first;
        logic [7:0] c;
        e.found = 1'b0; e.bad = 1'b0; e.aborted = 1'b0; e.result = '0; e.cycles = 0;
        if (from > to || to >= NUM_SYMBOLS) begin
            e.bad = 1'b1; e.cycles = 1;
            return e;
        end
        for (int i = 0; i < PW_LEN; i++) begin
            c = tgt[(PW_LEN - 1 - i) * 8 +: 8];
            if (sym_idx(c) < 0) ok = 1'b0;
            else pos = pos * NUM_SYMBOLS + sym_idx(c);
        end
        c = tgt[PW_W - 1 -: 8];
        first = sym_idx(c);
        if (ok && first >= from && first <= to) begin
            e.found  = 1'b1;
            e.result = tgt;
            e.cycles = pos - from * PER_FIRST + 1;
        end else begin
            e.cycles = (to - from + 1) * PER_FIRST;
        end
        return e;
    endfunction

    // Monitor: cnt = number of edges since the accept edge.
    int   cnt = 0;
    bit   armed = 1'b0;
    bit   have_cur = 1'b0;
    logic done_prev = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            armed = 1'b0; have_cur = 1'b0; done_prev = 1'b0;
        end else begin
            if (armed) cnt++;
            if (bus.done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("found",     bus.found,     cur.found);
                    check("bad_job",   bus.bad_job,   cur.bad);
                    check("aborted",   bus.aborted,   cur.aborted);
                    check("result_pw", bus.result_pw, cur.result);
                    check("latency",   armed ? cnt : -1, cur.cycles);
                    check("job_ready", bus.job_ready, 1);
`ifdef CRACK_ATTEMPT_COUNT_EN
                    check("attempts",  bus.attempts, cur.bad ? 0 : cur.cycles);
`endif
                end
                armed = 1'b0;
            end else if (bus.done && have_cur) begin
                check("hold", {bus.found, bus.bad_job, bus.aborted, bus.result_pw},
                      {cur.found, cur.bad, cur.aborted, cur.result});
            end
            if (bus.job_valid && bus.job_ready) begin
                armed = 1'b1; cnt = -1; have_cur = 1'b0;
            end
            done_prev = bus.done;
        end
    end

    task automatic issue(input logic [PW_W-1:0] tgt, input int from, input int to, input bit with_abort);
        @(posedge clk); #1;
        bus.job_valid  = 1'b1;
        bus.job_target = tgt;
        bus.job_from   = IDX_W'(from);
        bus.job_to     = IDX_W'(to);
        bus.abort      = with_abort;
        @(posedge clk); #1;
        bus.job_valid  = 1'b0;
        if (with_abort) begin
            @(posedge clk); #1;
            bus.abort = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_within_budget", bus.done, 1);
    endtask

    task automatic run_job(input logic [PW_W-1:0] tgt, input int from, input int to);
        exp_t e;
        e = model(tgt, from, to);
        exp_q.push_back(e);
        issue(tgt, from, to, 1'b0);
        wait_done(e.cycles + 10);
    endtask

    task automatic run_abort(input logic [PW_W-1:0] tgt, input int from, input int to, input int n);
        exp_t e;
        e.found = 1'b0; e.bad = 1'b0; e.aborted = 1'b1; e.result = '0; e.cycles = n + 1;
        exp_q.push_back(e);
        issue(tgt, from, to, 1'b0);
        repeat (n) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        wait_done(20);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},      bus.done,      0);
        check({tag, "_found"},     bus.found,     0);
        check({tag, "_bad_job"},   bus.bad_job,   0);
        check({tag, "_aborted"},   bus.aborted,   0);
        check({tag, "_result_pw"}, bus.result_pw, 0);
        check({tag, "_job_ready"}, bus.job_ready, 1);
`ifdef CRACK_ATTEMPT_COUNT_EN
        check({tag, "_attempts"},  bus.attempts,  0);
`endif
    endtask

    initial begin
        int from, to;
        exp_t e;
        bus.job_valid = 1'b0; bus.job_target = '0; bus.job_from = '0; bus.job_to = '0; bus.abort = 1'b0;

        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // directed cases
        run_job(32'h61626364, 0, 3);
        run_job(32'h61626364, 4, 4);
        run_job(32'h61626364, 5, 3);
        run_job(32'h61626364, 0, 36);
        run_abort(32'h7a7a7a7a, 25, 25, 100);

        e.found = 1'b1; e.bad = 1'b0; e.aborted = 1'b0; e.result = 32'h61616161; e.cycles = 1;
        exp_q.push_back(e);
        issue(32'h61616161, 0, 0, 1'b1);
        wait_done(20);

        // reset in the middle of a search: no result is expected for that job
        issue(32'h7a7a7a7a, 25, 25, 1'b0);
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(posedge clk); #1 rst = 1'b0;
        run_job(mk_pw(0, 0, 1, 35), 0, 0);

        // randomized jobs kept short by placing the target early in its range
        for (int j = 0; j < 8; j++) begin
            from = int'($urandom_range(0, 35));
            to   = int'($urandom_range(from, 35));
            run_job(mk_pw(from, int'($urandom_range(0, 1)), int'($urandom_range(0, 35)),
                          int'($urandom_range(0, 35))), from, to);
        end
        for (int j = 0; j < 2; j++) begin
            from = int'($urandom_range(1, 35));
            run_job(mk_pw(0, 0, 0, 0), from, int'($urandom_range(0, from - 1)));
        end
        from = int'($urandom_range(0, 35));
        run_abort(mk_pw(35, 35, 35, 35), from, from, int'($urandom_range(0, 60)));

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
